// File: rtl/mac_requant.sv
// Two-stage requantizer for MAC results: stage 1 rounds half-up to the output
// fraction, stage 2 saturates to the output width and tracks saturation and frame counts.
module mac_requant #(
    parameter int unsigned IN_INT   = 16,
    parameter int unsigned IN_FRAC  = 16,
    parameter int unsigned OUT_INT  = 8,
    parameter int unsigned OUT_FRAC = 8,
    parameter int unsigned CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [IN_INT+IN_FRAC-1:0]     s_data,
    input  logic                          s_valid,
    input  logic                          s_last,
    output logic                          s_ready,
    output logic [OUT_INT+OUT_FRAC-1:0]   m_data,
    output logic                          m_valid,
    output logic                          m_last,
    input  logic                          m_ready,
    input  logic                          clr_cnt,
    output logic [CNT_W-1:0]              sat_hi_cnt,
    output logic [CNT_W-1:0]              sat_lo_cnt,
    output logic [CNT_W-1:0]              frame_cnt
);

    localparam int unsigned W_IN  = IN_INT + IN_FRAC;
    localparam int unsigned W_OUT = OUT_INT + OUT_FRAC;
    localparam int unsigned W_EXT = W_IN + 1;
    localparam int unsigned SH    = IN_FRAC - OUT_FRAC;

    localparam logic signed [W_EXT-1:0] MAX_V = {{(W_EXT-W_OUT+1){1'b0}}, {(W_OUT-1){1'b1}}};
    localparam logic signed [W_EXT-1:0] MIN_V = {{(W_EXT-W_OUT+1){1'b1}}, {(W_OUT-1){1'b0}}};

    // Stage 1 state (rounded value, kept one bit wider than the input so nothing wraps)
    logic                    s1_valid_q, s1_valid_d;
    logic                    s1_last_q, s1_last_d;
    logic signed [W_EXT-1:0] s1_data_q, s1_data_d;

    // Stage 2 state (saturated value plus flags for the counters)
    logic                    s2_valid_q, s2_valid_d;
    logic                    s2_last_q, s2_last_d;
    logic                    s2_hi_q, s2_hi_d;
    logic                    s2_lo_q, s2_lo_d;
    logic [W_OUT-1:0]        s2_data_q, s2_data_d;

    logic [CNT_W-1:0]        hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0]        lo_cnt_q, lo_cnt_d;
    logic [CNT_W-1:0]        frm_cnt_q, frm_cnt_d;

    logic                    s1_load, s2_load, m_fire;
    logic signed [W_EXT-1:0] s_ext, s_rnd;
    logic                    sat_hi, sat_lo;
    logic [W_OUT-1:0]        sat_data;

    assign m_fire  = s2_valid_q && m_ready;
    assign s2_load = s1_valid_q && (!s2_valid_q || m_ready);
    assign s_ready = reset_n && (!s1_valid_q || s2_load);
    assign s1_load = s_valid && s_ready;

    assign s_ext = $signed({s_data[W_IN-1], s_data});

    generate
        if (SH == 0) begin : g_no_round
            assign s_rnd = s_ext;
        end else begin : g_round
            localparam logic signed [W_EXT-1:0] HALF = W_EXT'(64'd1 << (SH - 1));
            logic signed [W_EXT-1:0] sum;
            assign sum   = s_ext + HALF;
            assign s_rnd = sum >>> SH;
        end
    endgenerate

    always_comb begin
        sat_hi   = s1_data_q > MAX_V;
        sat_lo   = s1_data_q < MIN_V;
        sat_data = s1_data_q[W_OUT-1:0];
        if (sat_hi) begin
            sat_data = MAX_V[W_OUT-1:0];
        end else if (sat_lo) begin
            sat_data = MIN_V[W_OUT-1:0];
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic en);
        return (en && (c != {CNT_W{1'b1}})) ? c + CNT_W'(1) : c;
    endfunction

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_data_d  = s1_data_q;
        if (s1_load) begin
            s1_valid_d = 1'b1;
            s1_last_d  = s_last;
            s1_data_d  = s_rnd;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end

        s2_valid_d = s2_valid_q;
        s2_last_d  = s2_last_q;
        s2_hi_d    = s2_hi_q;
        s2_lo_d    = s2_lo_q;
        s2_data_d  = s2_data_q;
        if (s2_load) begin
            s2_valid_d = 1'b1;
            s2_last_d  = s1_last_q;
            s2_hi_d    = sat_hi;
            s2_lo_d    = sat_lo;
            s2_data_d  = sat_data;
        end else if (m_fire) begin
            s2_valid_d = 1'b0;
        end

        // Clear takes priority over any event counted in the same cycle
        if (clr_cnt) begin
            hi_cnt_d  = '0;
            lo_cnt_d  = '0;
            frm_cnt_d = '0;
        end else begin
            hi_cnt_d  = sat_inc(hi_cnt_q, m_fire && s2_hi_q);
            lo_cnt_d  = sat_inc(lo_cnt_q, m_fire && s2_lo_q);
            frm_cnt_d = sat_inc(frm_cnt_q, m_fire && s2_last_q);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_hi_q    <= 1'b0;
            s2_lo_q    <= 1'b0;
            s2_data_q  <= '0;
            hi_cnt_q   <= '0;
            lo_cnt_q   <= '0;
            frm_cnt_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_last_q  <= s2_last_d;
            s2_hi_q    <= s2_hi_d;
            s2_lo_q    <= s2_lo_d;
            s2_data_q  <= s2_data_d;
            hi_cnt_q   <= hi_cnt_d;
            lo_cnt_q   <= lo_cnt_d;
            frm_cnt_q  <= frm_cnt_d;
        end
    end

    assign m_valid    = s2_valid_q;
    assign m_last     = s2_last_q;
    assign m_data     = s2_data_q;
    assign sat_hi_cnt = hi_cnt_q;
    assign sat_lo_cnt = lo_cnt_q;
    assign frame_cnt  = frm_cnt_q;

endmodule

// File: tb/tb_mac_requant.sv
// Bench for mac_requant (Q16.16 -> Q8.8): vector table, directed corner sequences and a
// randomized run, all checked through an expected-beat queue and a counter model.
module tb_mac_requant;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        hi;
        logic        lo;
    } exp_t;

    typedef struct packed {
        logic [31:0] din;
        logic        last;
        logic [15:0] dout;
        logic        hi;
        logic        lo;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready = 1'b0;
    logic        clr_cnt = 1'b0;
    logic [15:0] sat_hi_cnt, sat_lo_cnt, frame_cnt;

    mac_requant dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .s_data     (s_data),
        .s_valid    (s_valid),
        .s_last     (s_last),
        .s_ready    (s_ready),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_last     (m_last),
        .m_ready    (m_ready),
        .clr_cnt    (clr_cnt),
        .sat_hi_cnt (sat_hi_cnt),
        .sat_lo_cnt (sat_lo_cnt),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;

    int   n_chk = 0;
    int   n_pass = 0;
    int   n_acc = 0;
    int   n_out = 0;
    exp_t sb[$];
    exp_t exp_cur;
    int   m_hi = 0, m_lo = 0, m_frm = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    function automatic exp_t model(input logic [31:0] x, input logic last);
        exp_t   e;
        longint v;
        v = longint'($signed(x));
        v = (v + 128) >>> 8;
        e.last = last;
        e.hi   = 1'b0;
        e.lo   = 1'b0;
        if (v > 32767) begin
            e.data = 16'h7fff;
            e.hi   = 1'b1;
        end else if (v < -32768) begin
            e.data = 16'h8000;
            e.lo   = 1'b1;
        end else begin
            e.data = v[15:0];
        end
        return e;
    endfunction

    // Inputs are set at the falling edge; handshakes are sampled 1 ns later.
    task automatic cycle();
        logic        acc, out, l;
        logic [15:0] d;
        exp_t        e;
        #1;
        acc = s_valid && s_ready;
        out = m_valid && m_ready;
        d   = m_data;
        l   = m_last;
        @(posedge clk);
        if (out) begin
            n_out++;
            if (sb.size() == 0) begin
                n_chk++;
                $display("FAIL unexpected_beat: got data %0h with nothing expected", d);
            end else begin
                e = sb.pop_front();
                chk("m_data", {48'd0, d}, {48'd0, e.data});
                chk("m_last", {63'd0, l}, {63'd0, e.last});
                if (!clr_cnt) begin
                    if (e.hi) m_hi++;
                    if (e.lo) m_lo++;
                    if (e.last) m_frm++;
                end
            end
        end
        if (clr_cnt) begin
            m_hi = 0; m_lo = 0; m_frm = 0;
        end
        if (acc) begin
            n_acc++;
            sb.push_back(exp_cur);
        end
        @(negedge clk);
    endtask

    task automatic drive(input logic [31:0] x, input logic last);
        s_valid = 1'b1;
        s_data  = x;
        s_last  = last;
        exp_cur = model(x, last);
    endtask

    task automatic drain();
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int i = 0; i < 20 && sb.size() > 0; i++) cycle();
        cycle();
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_counters(input string tag);
        chk({tag, "_sat_hi"}, {48'd0, sat_hi_cnt}, 64'(m_hi));
        chk({tag, "_sat_lo"}, {48'd0, sat_lo_cnt}, 64'(m_lo));
        chk({tag, "_frame"}, {48'd0, frame_cnt}, 64'(m_frm));
    endtask

    vec_t vecs[10];

    initial begin
        int          a0, o0;
        logic [15:0] held;
        logic        have_held;

        vecs[0] = '{32'h0001_8000, 1'b0, 16'h0180, 1'b0, 1'b0};
        vecs[1] = '{32'h0000_0080, 1'b0, 16'h0001, 1'b0, 1'b0};
        vecs[2] = '{32'hFFFF_FF7F, 1'b0, 16'hFFFF, 1'b0, 1'b0};
        vecs[3] = '{32'hFFFF_FF80, 1'b1, 16'h0000, 1'b0, 1'b0};
        vecs[4] = '{32'h0100_0000, 1'b0, 16'h7FFF, 1'b1, 1'b0};
        vecs[5] = '{32'h8000_0000, 1'b0, 16'h8000, 1'b0, 1'b1};
        vecs[6] = '{32'h007F_FF80, 1'b0, 16'h7FFF, 1'b1, 1'b0};
        vecs[7] = '{32'h007F_FF7F, 1'b0, 16'h7FFF, 1'b0, 1'b0};
        vecs[8] = '{32'hFF80_0000, 1'b0, 16'h8000, 1'b0, 1'b0};
        vecs[9] = '{32'hFF7F_FF7F, 1'b1, 16'h8000, 1'b0, 1'b1};

        // Reset state
        #2;
        chk("rst_s_ready", {63'd0, s_ready}, 64'd0);
        chk("rst_m_valid", {63'd0, m_valid}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        chk("post_rst_s_ready", {63'd0, s_ready}, 64'd1);
        chk("post_rst_m_valid", {63'd0, m_valid}, 64'd0);
        chk_counters("post_rst");
        @(negedge clk);

        // Vector table, one sample at a time to also observe latency
        m_ready = 1'b1;
        foreach (vecs[i]) begin
            s_valid = 1'b1;
            s_data  = vecs[i].din;
            s_last  = vecs[i].last;
            exp_cur = '{vecs[i].dout, vecs[i].last, vecs[i].hi, vecs[i].lo};
            cycle();
            s_valid = 1'b0;
            chk("lat_stage1", {63'd0, m_valid}, 64'd0);
            cycle();
            chk("lat_stage2", {63'd0, m_valid}, 64'd1);
            cycle();
        end
        chk("tbl_sat_hi", {48'd0, sat_hi_cnt}, 64'd2);
        chk("tbl_sat_lo", {48'd0, sat_lo_cnt}, 64'd2);
        chk("tbl_frame", {48'd0, frame_cnt}, 64'd2);
        chk_counters("tbl");

        // Clear concurrent with a saturated beat leaving
        m_ready = 1'b0;
        drive(32'h0100_0000, 1'b1);
        cycle();
        s_valid = 1'b0;
        cycle();
        cycle();
        m_ready = 1'b1;
        clr_cnt = 1'b1;
        cycle();
        clr_cnt = 1'b0;
        chk("clr_wins_hi", {48'd0, sat_hi_cnt}, 64'd0);
        chk("clr_wins_frame", {48'd0, frame_cnt}, 64'd0);
        chk_counters("clr");

        // Back-to-back 100 samples, last on the 100th
        a0 = n_acc;
        o0 = n_out;
        for (int i = 0; i < 100; i++) begin
            drive(32'h0000_1234 * i - 32'h0003_0000, i == 99);
            cycle();
        end
        chk("b2b_accepts", 64'(n_acc - a0), 64'd100);
        chk("b2b_outs_during", 64'(n_out - o0), 64'd98);
        s_valid = 1'b0;
        cycle();
        cycle();
        chk("b2b_outs", 64'(n_out - o0), 64'd100);
        chk("b2b_frame", {48'd0, frame_cnt}, 64'd1);
        chk_counters("b2b");

        // Stall: 6 cycles of back-pressure with continuous input
        m_ready   = 1'b0;
        a0        = n_acc;
        have_held = 1'b0;
        held      = '0;
        for (int i = 0; i < 6; i++) begin
            drive(32'h0002_0000 + 32'(i) * 32'h100, 1'b0);
            cycle();
            if (m_valid) begin
                if (!have_held) begin
                    held      = m_data;
                    have_held = 1'b1;
                end else begin
                    chk("stall_stable", {48'd0, m_data}, {48'd0, held});
                end
            end
        end
        chk("stall_accepts", 64'(n_acc - a0), 64'd2);
        #1;
        chk("stall_s_ready", {63'd0, s_ready}, 64'd0);
        @(negedge clk);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 3) == 0) drive($urandom, $urandom_range(0, 15) == 0);
            else drive(32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000,
                       $urandom_range(0, 15) == 0);
            s_valid = $urandom_range(0, 3) != 0;
            m_ready = $urandom_range(0, 2) != 0;
            clr_cnt = $urandom_range(0, 199) == 0;
            cycle();
        end
        clr_cnt = 1'b0;
        drain();
        chk_counters("rand");

        // Reset with two samples buffered
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(32'h0100_0000, 1'b1);
            cycle();
        end
        s_valid = 1'b0;
        chk("pre_rst_buffered", 64'(sb.size()), 64'd2);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_m_valid", {63'd0, m_valid}, 64'd0);
        chk("async_m_data", {48'd0, m_data}, 64'd0);
        chk("async_m_last", {63'd0, m_last}, 64'd0);
        chk("async_s_ready", {63'd0, s_ready}, 64'd0);
        sb.delete();
        m_hi = 0; m_lo = 0; m_frm = 0;
        chk_counters("async");
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("rel_s_ready", {63'd0, s_ready}, 64'd1);
        chk("rel_m_valid", {63'd0, m_valid}, 64'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) cycle();
        chk_counters("rel");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
